// File: rtl/ir_control_unit.sv
// ir_control_unit
//   Multi-cycle sequencer for the single-accumulator CPU. Walks each
//   instruction through FETCH -> DECODE -> (MEM | EXEC) and drives the
//   instruction register, PC, accumulator and memory handshake. Only one
//   instruction is in flight at a time.
//
// Ports
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   run                   enable, sampled in IDLE and at instruction boundaries
//   opcode[3:0]           decoded opcode from the instruction register
//   zero_flag             accumulator == 0
//   mem_ready             memory completes the current request this cycle
//   mem_req, mem_we       memory request (held until mem_ready) and write qualifier
//   addr_sel              0 = PC addresses memory, 1 = target_address
//   ir_load, pc_inc       fetch-complete strobes
//   pc_load, acc_load     jump and accumulator-write strobes
//   alu_op[2:0]           0 PASS, 1 ADD, 2 SUB, 3 AND, 4 OR
//   halted                core stopped; only reset leaves this state
//   bus_error             sticky memory-timeout flag
//   illegal_op            one-cycle pulse on an undefined opcode in DECODE
//   retired[CNT_W-1:0]    completed-instruction count, wrapping
module ir_control_unit #(
  parameter int MEM_TIMEOUT  = 16,
  parameter bit ILLEGAL_HALT = 1'b0,
  parameter int CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic [3:0]       opcode,
  input  logic             zero_flag,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_load,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             acc_load,
  output logic [2:0]       alu_op,
  output logic             halted,
  output logic             bus_error,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired
);

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_JUMP  = 4'h7;
  localparam logic [3:0] OP_JZ    = 4'h8;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_AND  = 3'd3;
  localparam logic [2:0] ALU_OR   = 3'd4;

  // The wait counter only ever needs to reach MEM_TIMEOUT-1.
  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_MEM,
    ST_EXEC,
    ST_HALT
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [WAIT_W-1:0] wait_cnt;
  logic              wait_expired;
  logic              boundary;
  logic              timeout;

  function automatic logic [2:0] alu_sel(input logic [3:0] op);
    case (op)
      OP_ADD:  alu_sel = ALU_ADD;
      OP_SUB:  alu_sel = ALU_SUB;
      OP_AND:  alu_sel = ALU_AND;
      OP_OR:   alu_sel = ALU_OR;
      default: alu_sel = ALU_PASS;
    endcase
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    is_illegal = (op >= 4'h9) && (op <= 4'hE);
  endfunction

  // mem_ready in the last allowed cycle still wins over the timeout.
  assign wait_expired = (MEM_TIMEOUT != 0) && (wait_cnt == WAIT_LAST);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic; boundary marks the cycle an instruction retires
  always_comb begin
    state_n  = state;
    boundary = 1'b0;
    timeout  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (run) state_n = ST_FETCH;
      end
      ST_FETCH: begin
        if (mem_ready) begin
          state_n = ST_DECODE;
        end else if (wait_expired) begin
          timeout = 1'b1;
          state_n = ST_HALT;
        end
      end
      ST_DECODE: begin
        case (opcode)
          OP_NOP, OP_JUMP, OP_JZ:         boundary = 1'b1;
          OP_LOAD, OP_STORE:              state_n  = ST_MEM;
          OP_ADD, OP_SUB, OP_AND, OP_OR:  state_n  = ST_EXEC;
          OP_HALT:                        state_n  = ST_HALT;
          default: begin
            if (ILLEGAL_HALT) state_n  = ST_HALT;
            else              boundary = 1'b1;
          end
        endcase
      end
      ST_MEM: begin
        if (mem_ready) begin
          boundary = 1'b1;
        end else if (wait_expired) begin
          timeout = 1'b1;
          state_n = ST_HALT;
        end
      end
      ST_EXEC: begin
        boundary = 1'b1;
      end
      ST_HALT: begin
        state_n = ST_HALT;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
    if (boundary) state_n = run ? ST_FETCH : ST_IDLE;
  end

  // Wait counter restarts on every entry into FETCH or MEM
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if ((MEM_TIMEOUT != 0) && (state == ST_FETCH || state == ST_MEM)
                 && (state_n == state)) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      retired   <= '0;
      bus_error <= 1'b0;
    end else begin
      if (boundary) retired   <= retired + CNT_W'(1);
      if (timeout)  bus_error <= 1'b1;
    end
  end

  // Outputs: request/select/alu_op/halted follow the state; strobes also
  // depend on the inputs of the current cycle.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_sel   = 1'b0;
    ir_load    = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    acc_load   = 1'b0;
    alu_op     = ALU_PASS;
    halted     = 1'b0;
    illegal_op = 1'b0;
    case (state)
      ST_FETCH: begin
        mem_req = 1'b1;
        ir_load = mem_ready;
        pc_inc  = mem_ready;
      end
      ST_DECODE: begin
        pc_load    = (opcode == OP_JUMP) || ((opcode == OP_JZ) && zero_flag);
        illegal_op = is_illegal(opcode);
      end
      ST_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = (opcode == OP_STORE);
        acc_load = mem_ready && (opcode == OP_LOAD);
      end
      ST_EXEC: begin
        alu_op   = alu_sel(opcode);
        acc_load = 1'b1;
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ir_control_unit.sv
module tb_ir_control_unit;

  localparam int MT = 16;
  localparam int CW = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Main instance: illegal opcodes act as NOP, 16-cycle timeout, 4-bit counter
  logic          reset, run, zero_flag, mem_ready;
  logic [3:0]    opcode;
  logic          mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load, acc_load;
  logic          halted, bus_error, illegal_op;
  logic [2:0]    alu_op;
  logic [CW-1:0] retired;

  ir_control_unit #(.MEM_TIMEOUT(MT), .ILLEGAL_HALT(1'b0), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .run(run), .opcode(opcode),
    .zero_flag(zero_flag), .mem_ready(mem_ready), .mem_req(mem_req),
    .mem_we(mem_we), .addr_sel(addr_sel), .ir_load(ir_load), .pc_inc(pc_inc),
    .pc_load(pc_load), .acc_load(acc_load), .alu_op(alu_op), .halted(halted),
    .bus_error(bus_error), .illegal_op(illegal_op), .retired(retired)
  );

  // Second instance: illegal opcodes halt, timeout disabled
  logic        h_reset, h_run, h_zero, h_ready;
  logic [3:0]  h_opcode;
  logic        h_mem_req, h_mem_we, h_addr_sel, h_ir_load, h_pc_inc, h_pc_load;
  logic        h_acc_load, h_halted, h_bus_error, h_illegal_op;
  logic [2:0]  h_alu_op;
  logic [15:0] h_retired;

  ir_control_unit #(.MEM_TIMEOUT(0), .ILLEGAL_HALT(1'b1), .CNT_W(16)) dut_h (
    .clock(clock), .reset(h_reset), .run(h_run), .opcode(h_opcode),
    .zero_flag(h_zero), .mem_ready(h_ready), .mem_req(h_mem_req),
    .mem_we(h_mem_we), .addr_sel(h_addr_sel), .ir_load(h_ir_load),
    .pc_inc(h_pc_inc), .pc_load(h_pc_load), .acc_load(h_acc_load),
    .alu_op(h_alu_op), .halted(h_halted), .bus_error(h_bus_error),
    .illegal_op(h_illegal_op), .retired(h_retired)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state
  int m_retired;
  bit m_bus;

  // Event tallies gathered at each sample point
  int         n_cyc = 0;
  int         c_req = 0, c_we = 0, c_acc = 0, c_pcl = 0, c_ill = 0;
  logic [2:0] last_acc_alu = 3'd0;

  function automatic logic [11:0] pk(input bit req, input bit we, input bit asel,
                                     input bit irl, input bit pci, input bit pcl,
                                     input bit accl, input logic [2:0] alu,
                                     input bit hlt, input bit ill);
    return {req, we, asel, irl, pci, pcl, accl, alu, hlt, ill};
  endfunction

  function automatic logic [2:0] alu_of(input logic [3:0] op);
    case (op)
      4'h3:    return 3'd1;
      4'h4:    return 3'd2;
      4'h5:    return 3'd3;
      4'h6:    return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic lit(input string name, input longint act, input longint expv);
    n_chk++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // One clock cycle: inputs already driven; sample at the falling edge,
  // compare against the expected outputs, then advance the model.
  task automatic step(input logic [11:0] e, input bit bnd, input bit tmo);
    logic [11:0] a;
    @(negedge clock);
    a = {mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load, acc_load,
         alu_op, halted, illegal_op};
    n_cyc++;
    if (mem_req)    c_req++;
    if (mem_we)     c_we++;
    if (pc_load)    c_pcl++;
    if (illegal_op) c_ill++;
    if (acc_load) begin
      c_acc++;
      last_acc_alu = alu_op;
    end
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL outputs @%0t: got %b, expected %b (req we asel irl pci pcl accl alu3 hlt ill)",
               $time, a, e);
    end
    n_chk++;
    if (bus_error !== m_bus) begin
      n_fail++;
      $display("FAIL bus_error @%0t: got %b, expected %b", $time, bus_error, m_bus);
    end
    n_chk++;
    if (retired !== CW'(m_retired)) begin
      n_fail++;
      $display("FAIL retired @%0t: got %0d, expected %0d", $time, retired, m_retired);
    end
    @(posedge clock);
    #1;
    if (bnd) m_retired = (m_retired + 1) % (1 << CW);
    if (tmo) m_bus = 1'b1;
  endtask

  task automatic rand_in();
    run       = rb();
    zero_flag = rb();
    mem_ready = rb();
    opcode    = 4'($urandom_range(0, 15));
  endtask

  task automatic set_run(input int sel);
    if (sel == 2) run = rb();
    else          run = (sel != 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m_retired = 0;
    m_bus = 1'b0;
    repeat (2) begin
      rand_in();
      step(12'd0, 1'b0, 1'b0);
    end
    reset = 1'b0;
  endtask

  task automatic idle_enter();
    int n;
    n = $urandom_range(0, 3);
    for (int i = 0; i < n; i++) begin
      rand_in();
      run = 1'b0;
      step(12'd0, 1'b0, 1'b0);
    end
    rand_in();
    run = 1'b1;
    step(12'd0, 1'b0, 1'b0);
  endtask

  task automatic halt_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      rand_in();
      step(pk(0, 0, 0, 0, 0, 0, 0, 3'd0, 1, 0), 1'b0, 1'b0);
    end
  endtask

  // Expected per-cycle trace for one instruction.
  //   fw/mw : cycles without mem_ready before the fetch / memory request completes
  //   zf    : zero_flag in DECODE (0/1, 2 = random)
  //   rsel  : run at the retiring cycle (0/1, 2 = random)
  task automatic do_instr(input logic [3:0] op, input int fw, input int mw,
                          input int zf, input int rsel,
                          output bit stopped, output bit last_run);
    bit st;
    stopped  = 1'b0;
    last_run = 1'b0;
    st       = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      rand_in();
      mem_ready = (k >= fw);
      if (k >= fw) begin
        step(pk(1, 0, 0, 1, 1, 0, 0, 3'd0, 0, 0), 1'b0, 1'b0);
        break;
      end
      if (k == MT - 1) begin
        step(pk(1, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0), 1'b0, 1'b1);
        st = 1'b1;
        break;
      end
      step(pk(1, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0), 1'b0, 1'b0);
    end
    if (st) begin
      stopped = 1'b1;
      return;
    end

    rand_in();
    opcode = op;
    if (zf != 2) zero_flag = (zf != 0);
    if (op == 4'h0 || op == 4'h7 || op == 4'h8 || (op >= 4'h9 && op <= 4'hE)) begin
      set_run(rsel);
      last_run = run;
      step(pk(0, 0, 0, 0, 0, (op == 4'h7) || (op == 4'h8 && zero_flag), 0, 3'd0, 0,
              (op >= 4'h9 && op <= 4'hE)), 1'b1, 1'b0);
      return;
    end
    step(12'd0, 1'b0, 1'b0);
    if (op == 4'hF) begin
      stopped = 1'b1;
      return;
    end

    if (op == 4'h1 || op == 4'h2) begin
      for (int k = 0; k < 1000; k++) begin
        rand_in();
        opcode = op;
        mem_ready = (k >= mw);
        if (k >= mw) begin
          set_run(rsel);
          last_run = run;
          step(pk(1, op == 4'h2, 1, 0, 0, 0, op == 4'h1, 3'd0, 0, 0), 1'b1, 1'b0);
          break;
        end
        if (k == MT - 1) begin
          step(pk(1, op == 4'h2, 1, 0, 0, 0, 0, 3'd0, 0, 0), 1'b0, 1'b1);
          stopped = 1'b1;
          break;
        end
        step(pk(1, op == 4'h2, 1, 0, 0, 0, 0, 3'd0, 0, 0), 1'b0, 1'b0);
      end
      return;
    end

    rand_in();
    opcode = op;
    set_run(rsel);
    last_run = run;
    step(pk(0, 0, 0, 0, 0, 0, 1, alu_of(op), 0, 0), 1'b1, 1'b0);
  endtask

  function automatic logic [3:0] pick_op();
    int r;
    r = $urandom_range(0, 99);
    if (r < 2) return 4'hF;
    if (r < 7) return 4'($urandom_range(9, 14));
    return 4'($urandom_range(0, 8));
  endfunction

  function automatic int pick_wait();
    if ($urandom_range(0, 99) < 3) return $urandom_range(14, 20);
    return $urandom_range(0, 3);
  endfunction

  initial begin
    bit st, lr, idle;
    int b0, b1;
    logic [3:0] op;
    reset = 1'b1; run = 1'b0; opcode = 4'h0; zero_flag = 1'b0; mem_ready = 1'b0;
    h_reset = 1'b1; h_run = 1'b0; h_opcode = 4'h0; h_zero = 1'b0; h_ready = 1'b0;

    // ADD with zero-wait memory: 3 cycles, ALU ADD on the accumulator write
    do_reset();
    lit("reset_retired", longint'(retired), 0);
    lit("reset_halted", longint'(halted), 0);
    idle_enter();
    b0 = n_cyc;
    do_instr(4'h3, 0, 0, 2, 1, st, lr);
    lit("add_cycles", n_cyc - b0, 3);
    lit("add_alu_at_acc_load", longint'(last_acc_alu), 1);
    lit("add_retired", longint'(retired), 1);

    // JZ taken then JZ not taken
    b0 = c_pcl;
    do_instr(4'h8, 0, 0, 1, 1, st, lr);
    do_instr(4'h8, 0, 0, 0, 1, st, lr);
    lit("jz_pc_load_pulses", c_pcl - b0, 1);
    lit("jz_retired", longint'(retired), 3);

    // STORE with 5 wait cycles
    b0 = c_we;
    b1 = c_acc;
    do_instr(4'h2, 0, 5, 2, 1, st, lr);
    lit("store_we_cycles", c_we - b0, 6);
    lit("store_no_acc_load", c_acc - b1, 0);
    lit("store_back_to_fetch", longint'(mem_req), 1);

    // run dropped at the end of EXEC, then re-enabled
    do_instr(4'h4, 0, 0, 2, 0, st, lr);
    lit("sub_retired_to_idle_req", longint'(mem_req), 0);
    lit("sub_retired", longint'(retired), 5);
    idle_enter();
    lit("rerun_fetch_req", longint'(mem_req), 1);

    // Illegal opcode treated as NOP, then HALT
    b0 = c_ill;
    do_instr(4'hA, 0, 0, 2, 1, st, lr);
    lit("illegal_pulses", c_ill - b0, 1);
    lit("illegal_not_stopped", st, 0);
    lit("illegal_retired", longint'(retired), 6);
    do_instr(4'hF, 0, 0, 2, 1, st, lr);
    lit("halt_op_halted", longint'(halted), 1);
    lit("halt_op_retired", longint'(retired), 6);
    halt_cycles(4);

    // Fetch never answered
    do_reset();
    idle_enter();
    b0 = c_req;
    do_instr(4'h3, 100, 0, 2, 1, st, lr);
    lit("timeout_req_cycles", c_req - b0, 16);
    lit("timeout_bus_error", longint'(bus_error), 1);
    lit("timeout_halted", longint'(halted), 1);
    lit("timeout_retired", longint'(retired), 0);
    halt_cycles(3);

    // mem_ready in the last allowed wait cycle is still accepted
    do_reset();
    idle_enter();
    do_instr(4'h1, 15, 15, 2, 1, st, lr);
    lit("last_wait_accepted", st, 0);
    lit("last_wait_no_bus_error", longint'(bus_error), 0);
    lit("last_wait_retired", longint'(retired), 1);

    // Reset arriving in the middle of a memory request
    rand_in();
    mem_ready = 1'b1;
    step(pk(1, 0, 0, 1, 1, 0, 0, 3'd0, 0, 0), 1'b0, 1'b0);
    rand_in();
    opcode = 4'h1;
    step(12'd0, 1'b0, 1'b0);
    rand_in();
    opcode = 4'h1;
    mem_ready = 1'b0;
    step(pk(1, 0, 1, 0, 0, 0, 0, 3'd0, 0, 0), 1'b0, 1'b0);
    mem_ready = 1'b0;
    #1;
    lit("mid_mem_req", longint'(mem_req), 1);
    reset = 1'b1;
    #1;
    lit("reset_mid_mem_outputs",
        longint'({mem_req, addr_sel, mem_we, acc_load, ir_load, halted}), 0);
    lit("reset_mid_mem_retired", longint'(retired), 0);

    // Randomized instruction streams
    for (int ep = 0; ep < 25; ep++) begin
      do_reset();
      idle = 1'b1;
      for (int i = 0; i < 40; i++) begin
        if (idle) idle_enter();
        op = pick_op();
        do_instr(op, pick_wait(), pick_wait(), 2, 2, st, lr);
        if (st) begin
          halt_cycles($urandom_range(1, 4));
          break;
        end
        idle = !lr;
      end
    end

    // Halting-on-illegal instance with the timeout disabled
    @(posedge clock);
    #1;
    h_reset = 1'b0;
    h_run = 1'b1;
    @(posedge clock);
    #1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
    end
    lit("no_timeout_bus_error", longint'(h_bus_error), 0);
    lit("no_timeout_still_req", longint'(h_mem_req), 1);
    h_ready = 1'b1;
    #1;
    lit("no_timeout_ir_load", longint'(h_ir_load), 1);
    @(posedge clock);
    #1;
    h_ready = 1'b0;
    h_opcode = 4'hA;
    #1;
    lit("illegal_halt_pulse", longint'(h_illegal_op), 1);
    lit("illegal_halt_not_yet", longint'(h_halted), 0);
    @(posedge clock);
    #1;
    lit("illegal_halt_halted", longint'(h_halted), 1);
    lit("illegal_halt_retired", longint'(h_retired), 0);
    lit("illegal_halt_req", longint'(h_mem_req), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
